// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: handshake and operand/result bundle between the control unit
// and the iterative multiply/divide sequencer.
//   start, op, a, b  : request side (control unit drives)
//   busy, done       : sequencer status
//   div_zero         : divide-by-zero pulse, coincident with done
//   hilo_we          : HI/LO write strobe (done & ~div_zero)
//   hi, lo           : registered result pair, held until next completion
interface muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hilo_we, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hilo_we, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed 32x32 multiply / 32/32 divide sequencer.
// A start in IDLE latches op/a/b; the operation runs on unsigned magnitudes
// for 32 steps (shift-add multiply or restoring divide), signs are fixed up
// in FIX, HI/LO are loaded on entry to DONE, and done pulses for one cycle.
// Divide by zero skips straight to DONE with div_zero set and HI/LO untouched.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high, clears all state including HI/LO
//   bus    : muldiv_seq_if slave (start/op/a/b in; busy/done/div_zero/
//            hilo_we/hi/lo out)
module muldiv_seq (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_op;
  logic        r_dz;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic [31:0] r_a;
  logic [31:0] r_b;
  // Multiplicand magnitude (MULT) or divisor magnitude (DIV).
  logic [31:0] r_opnd;
  // Multiplier bits shifting out (MULT) or dividend in / quotient out (DIV).
  logic [31:0] r_q;
  // Partial product (MULT) or partial remainder in [31:0] (DIV).
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_dz_req;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_msum;
  logic [63:0] w_mul_acc;
  logic [32:0] w_rsh;
  logic [32:0] w_rdiff;
  logic        w_qbit;
  logic [31:0] w_rnew;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_dz_req = bus.op & (bus.b == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_dz_req ? S_DONE : S_PREP;
      S_PREP:  w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_PREP, S_RUN, S_FIX: w_busy = 1'b1;
      S_DONE:               w_done = 1'b1;
      default:              ;
    endcase
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.div_zero = w_done & r_dz;
  assign bus.hilo_we  = w_done & ~r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

  // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned value.
  assign w_abs_a = r_a[31] ? ('0 - r_a) : r_a;
  assign w_abs_b = r_b[31] ? ('0 - r_b) : r_b;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign w_msum    = {1'b0, r_acc[63:32]} + {1'b0, (r_q[0] ? r_opnd : '0)};
  assign w_mul_acc = {w_msum, r_acc[31:1]};

  // Restoring step: shift next dividend bit into the remainder and try the
  // subtract; a borrow in bit 32 means keep the shifted remainder.
  assign w_rsh   = {r_acc[31:0], r_q[31]};
  assign w_rdiff = w_rsh - {1'b0, r_opnd};
  assign w_qbit  = ~w_rdiff[32];
  assign w_rnew  = w_qbit ? w_rdiff[31:0] : w_rsh[31:0];

  // Sign fix-up of the unsigned results
  assign w_prod = r_neg_res ? ('0 - r_acc) : r_acc;
  assign w_quot = r_neg_res ? ('0 - r_q) : r_q;
  assign w_rem  = r_neg_rem ? ('0 - r_acc[31:0]) : r_acc[31:0];

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 1'b0;
      r_dz      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_opnd    <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
            r_dz <= w_dz_req;
          end
        end
        S_PREP: begin
          r_neg_res <= r_a[31] ^ r_b[31];
          r_neg_rem <= r_a[31];
          r_opnd    <= r_op ? w_abs_b : w_abs_a;
          r_q       <= r_op ? w_abs_a : w_abs_b;
          r_acc     <= '0;
          r_cnt     <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op) begin
            r_acc <= {32'd0, w_rnew};
            r_q   <= {r_q[30:0], w_qbit};
          end else begin
            r_acc <= w_mul_acc;
            r_q   <= {1'b0, r_q[31:1]};
          end
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset;

  muldiv_seq_if u_if ();

  muldiv_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed arithmetic reference: product via 64-bit multiply, quotient and
  // remainder via truncating signed division (remainder takes dividend sign).
  function automatic void ref_result(input logic op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint sa;
    longint sb;
    longint r;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    if (!op) begin
      r  = sa * sb;
      hi = r[63:32];
      lo = r[31:0];
    end else if (b != 0) begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Transaction-level model: age counts edges since the accepting edge.
  bit          m_act = 1'b0;
  bit          m_dz  = 1'b0;
  int          m_j   = 0;
  int          m_dj  = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic [31:0] m_nhi = '0;
  logic [31:0] m_nlo = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      m_dz  = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_act) begin
      m_j++;
      if (!m_dz && m_j == 34) begin
        m_hi = m_nhi;
        m_lo = m_nlo;
      end
      if (m_j > m_dj) m_act = 1'b0;
    end else if (u_if.start === 1'b1) begin
      m_act = 1'b1;
      m_j   = 0;
      m_dz  = u_if.op && (u_if.b == 0);
      m_dj  = m_dz ? 0 : 34;
      ref_result(u_if.op, u_if.a, u_if.b, m_nhi, m_nlo);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy, e_done;
      e_busy = m_act && !m_dz && (m_j <= 33);
      e_done = m_act && (m_j == m_dj);
      chk("busy",     u_if.busy,     e_busy);
      chk("done",     u_if.done,     e_done);
      chk("div_zero", u_if.div_zero, e_done && m_dz);
      chk("hilo_we",  u_if.hilo_we,  e_done && !m_dz);
      chk("hi",       u_if.hi,       m_hi);
      chk("lo",       u_if.lo,       m_lo);
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!m_act) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat,
                        input logic edz);
    int  lat;
    bit  busy_seen;
    lat = 0;
    busy_seen = 1'b0;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.op = ~op; u_if.a = $urandom; u_if.b = $urandom;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (u_if.busy) busy_seen = 1'b1;
      if (u_if.done) begin
        lat = n;
        chk({nm, "_hi"},      u_if.hi, ehi);
        chk({nm, "_lo"},      u_if.lo, elo);
        chk({nm, "_dz"},      u_if.div_zero, edz);
        chk({nm, "_we"},      u_if.hilo_we, !edz);
        break;
      end
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busyseen"}, busy_seen, !edz);
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl;
    int first_done, second_done, ndone;

    reset = 1'b1;
    u_if.start = 1'b0; u_if.op = 1'b0; u_if.a = '0; u_if.b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_hi",   u_if.hi, 0);
    chk("rst_lo",   u_if.lo, 0);

    // Pin the reference model with hand-computed values.
    ref_result(1'b0, 32'd7, 32'hFFFF_FFFD, rh, rl);
    chk("ref_mul_7x-3", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);
    ref_result(1'b0, 32'h8000_0000, 32'h8000_0000, rh, rl);
    chk("ref_mul_min2", {rh, rl}, 64'h4000_0000_0000_0000);
    ref_result(1'b1, 32'hFFFF_FFF9, 32'd2, rh, rl);
    chk("ref_div_-7/2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
    ref_result(1'b1, 32'd7, 32'hFFFF_FFFE, rh, rl);
    chk("ref_div_7/-2", {rh, rl}, 64'h0000_0001_FFFF_FFFD);
    ref_result(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl);
    chk("ref_div_ovf", {rh, rl}, 64'h0000_0000_8000_0000);

    run_op("mul_7x-3",  1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 35, 1'b0);
    run_op("mul_min2",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 35, 1'b0);
    run_op("mul_m1m1",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 35, 1'b0);
    run_op("div_-7/2",  1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1'b0);
    run_op("div_7/-2",  1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 35, 1'b0);
    run_op("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35, 1'b0);
    run_op("div_prior", 1'b1, 32'h0ACF_1234, 32'h0000_2000, 32'h1234, 32'h5678, 35, 1'b0);
    run_op("div_zero",  1'b1, 32'd5, 32'h0, 32'h1234, 32'h5678, 1, 1'b1);

    // Start pulses while busy are ignored.
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.op = 1'b0; u_if.a = 32'd6; u_if.b = 32'd7;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    ndone = 0; first_done = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (u_if.done) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
      u_if.start = (n == 5 || n == 20);
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_first", first_done, 35);
    chk("ign_lo", u_if.lo, 42);
    wait_idle();

    // Start held high: second accept only after DONE -> IDLE.
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.op = 1'b0; u_if.a = 32'd5; u_if.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    first_done = 0; second_done = 0;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (u_if.done) begin
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
      if (n == 71) u_if.start = 1'b0;
    end
    chk("b2b_first", first_done, 35);
    chk("b2b_gap", second_done - first_done, 36);
    chk("b2b_lo", u_if.lo, 32'hFFFF_FFFB);
    wait_idle();

    // Reset during RUN with counter at 10.
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.op = 1'b0; u_if.a = 32'd9; u_if.b = 32'd9;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (u_if.done) ndone++;
      if (n == 13) begin
        chk("rstrun_busy", u_if.busy, 0);
        chk("rstrun_hi", u_if.hi, 0);
        chk("rstrun_lo", u_if.lo, 0);
      end
      reset = (n == 12);
    end
    chk("rstrun_ndone", ndone, 0);
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 35, 1'b0);

    // Randomized traffic with junk starts, operand churn and occasional resets.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      u_if.start = 1'b1;
      u_if.op = 1'($urandom_range(0, 1));
      u_if.a = pick();
      u_if.b = pick();
      reset = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 120; c++) begin
        @(posedge clk); #1;
        u_if.start = m_act && (m_j < 30) && ($urandom_range(0, 9) == 0);
        u_if.op = 1'($urandom_range(0, 1));
        u_if.a = $urandom;
        u_if.b = $urandom;
        reset = m_act && ($urandom_range(0, 99) < 2);
        if (!m_act && !reset && !u_if.start) break;
        if (c == 119) chk("rand_timeout", 0, 1);
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
